// File: rtl/packet_mem_to_tx_pkg.sv
// Shared definitions for the packet memory to transmit replay block.
//   state_t     : controller states
//   DEF_IFG     : default number of idle cycles after each packet
//   PIPE_DEPTH  : memory read latency plus transmit output register
package packet_mem_to_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        GAP
    } state_t;

    localparam int         DEF_IFG    = 12;
    localparam logic [1:0] PIPE_DEPTH = 2'd2;

endpackage

// File: rtl/packet_mem_to_tx_if.sv
// Bus bundle between the upstream packet buffer / memory and the replay block.
//   iempty, ilen_pac : upstream head-packet status
//   ir_data          : memory read data (one cycle after or_addr)
//   or_addr          : memory read address
//   otx_en, otxd     : GMII-style transmit valid and byte
//   opkt_done        : one-cycle release pulse for the head packet
//   obusy            : controller not idle
// master = replay block side, slave = buffer/memory/PHY side.
interface packet_mem_to_tx_if #(
    parameter int pRB_WIDHT  = 14,
    parameter int pMEM_WIDTH = 8,
    parameter int pLEN_WIDTH = 11
);
    logic                  iempty;
    logic [pLEN_WIDTH-1:0] ilen_pac;
    logic [pMEM_WIDTH-1:0] ir_data;
    logic [pRB_WIDHT-1:0]  or_addr;
    logic                  otx_en;
    logic [pMEM_WIDTH-1:0] otxd;
    logic                  opkt_done;
    logic                  obusy;

    modport master (
        input  iempty, ilen_pac, ir_data,
        output or_addr, otx_en, otxd, opkt_done, obusy
    );

    modport slave (
        output iempty, ilen_pac, ir_data,
        input  or_addr, otx_en, otxd, opkt_done, obusy
    );
endinterface

// File: rtl/packet_mem_to_tx.sv
// Replays stored packets from the receive ring buffer onto a byte-serial
// transmit interface, releasing each packet upstream and inserting an
// inter-frame gap after it.
//   iclk  : clock
//   i_rst : asynchronous active-low reset
//   bus   : packet_mem_to_tx_if master modport (status in, memory, tx out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | wait for a complete packet upstream
// LOAD  | latch head-packet length; zero length is released immediately
// READ  | issue one read address per cycle, rd_ptr + cnt
// DRAIN | let the last bytes leave the memory/output pipeline
// GAP   | release packet, advance rd_ptr, hold off for pIFG cycles
module packet_mem_to_tx
    import packet_mem_to_tx_pkg::*;
#(
    parameter int pRB_WIDHT  = 14,
    parameter int pMEM_WIDTH = 8,
    parameter int pLEN_WIDTH = 11,
    parameter int pIFG       = DEF_IFG
) (
    input  logic                iclk,
    input  logic                i_rst,
    packet_mem_to_tx_if.master  bus
);

    localparam int TMR_W = $clog2(pIFG + 1) + 1;

    localparam logic [TMR_W-1:0]      ONE_T    = TMR_W'(1);
    localparam logic [TMR_W-1:0]      GAP_TC   = TMR_W'(pIFG - 1);
    localparam logic [TMR_W-1:0]      DRAIN_TC = TMR_W'(PIPE_DEPTH - 2'd1);
    localparam logic [pLEN_WIDTH-1:0] ONE_L    = pLEN_WIDTH'(1);
    localparam logic [pRB_WIDHT-1:0]  ONE_A    = pRB_WIDHT'(1);

    state_t                state;
    logic [pRB_WIDHT-1:0]  rd_ptr;
    logic [pLEN_WIDTH-1:0] cnt;
    logic [pLEN_WIDTH-1:0] len;
    logic [TMR_W-1:0]      tmr;
    // vld[0] lines up with ir_data, vld[1] with the registered transmit byte
    logic [1:0]            vld;
    logic [pRB_WIDHT-1:0]  next_ptr;

    assign next_ptr   = rd_ptr + pRB_WIDHT'(len);
    assign bus.otx_en = vld[1];

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            cnt           <= '0;
            len           <= '0;
            tmr           <= '0;
            vld           <= '0;
            bus.or_addr   <= '0;
            bus.otxd      <= '0;
            bus.opkt_done <= 1'b0;
            bus.obusy     <= 1'b0;
        end else begin
            bus.opkt_done <= 1'b0;
            vld           <= {vld[0], state == READ};
            bus.otxd      <= vld[0] ? bus.ir_data : pMEM_WIDTH'(0);

            case (state)
                IDLE: begin
                    if (!bus.iempty) begin
                        state     <= LOAD;
                        bus.obusy <= 1'b1;
                    end
                end
                LOAD: begin
                    len <= bus.ilen_pac;
                    cnt <= '0;
                    if (bus.ilen_pac == '0) begin
                        state         <= IDLE;
                        bus.opkt_done <= 1'b1;
                        bus.obusy     <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    cnt <= cnt + ONE_L;
                    if (cnt == len - ONE_L) begin
                        state       <= DRAIN;
                        tmr         <= DRAIN_TC;
                        bus.or_addr <= rd_ptr;
                    end else begin
                        // registered address: present the next byte's address
                        bus.or_addr <= rd_ptr + pRB_WIDHT'(cnt) + ONE_A;
                    end
                end
                DRAIN: begin
                    if (tmr == '0) begin
                        state         <= GAP;
                        tmr           <= GAP_TC;
                        rd_ptr        <= next_ptr;
                        bus.or_addr   <= next_ptr;
                        bus.opkt_done <= 1'b1;
                    end else begin
                        tmr <= tmr - ONE_T;
                    end
                end
                GAP: begin
                    if (tmr == '0) begin
                        state     <= IDLE;
                        bus.obusy <= 1'b0;
                    end else begin
                        tmr <= tmr - ONE_T;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.obusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
